// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: p processor requesters plus one control-unit
// status-write port share one synchronous memory. The control unit always
// wins; processors are served round-robin. Each access takes three cycles:
// select (s_Idle), drive the memory (s_Access), complete (s_Respond).
module mem_port_arbiter #(
   parameter int p               = 4,
   parameter int data_width      = 32,
   parameter int memory_size_log = 10
) (
   input  logic                           i_Clock,
   input  logic                           i_Reset,
   input  logic [p-1:0]                   i_Req,
   input  logic [p-1:0]                   i_Write,
   input  logic [p*memory_size_log-1:0]   i_Addr,
   input  logic [p*data_width-1:0]        i_Write_Data,
   input  logic                           i_CU_Req,
   input  logic [memory_size_log-1:0]     i_CU_Addr,
   input  logic [data_width-1:0]          i_CU_Write_Data,
   input  logic [data_width-1:0]          i_Mem_Read_Data,
   output logic [memory_size_log-1:0]     o_Mem_Addr,
   output logic [data_width-1:0]          o_Mem_Write_Data,
   output logic                           o_Mem_Write_Enable,
   output logic [p:0]                     o_Grant,
   output logic [p:0]                     o_Ack,
   output logic [data_width-1:0]          o_Read_Data
);

   // Pointer/winner width; at least one bit so p = 1 still elaborates.
   localparam int PW = (p > 1) ? $clog2(p) : 1;

   typedef enum logic [1:0] {
      s_Idle    = 2'd0,
      s_Access  = 2'd1,
      s_Respond = 2'd2
   } t_State;

   t_State                       r_State;
   logic [PW-1:0]                r_Pointer;
   logic [PW-1:0]                r_Winner;
   logic                         r_Win_Cu;
   logic                         r_Win_Write;
   logic [p:0]                   r_Grant;
   logic [p:0]                   r_Ack;
   logic [memory_size_log-1:0]   r_Mem_Addr;
   logic [data_width-1:0]        r_Mem_Write_Data;
   logic                         r_Mem_Write_Enable;
   logic [data_width-1:0]        r_Read_Data;

   logic                         w_Found;
   logic [PW-1:0]                w_Sel;
   logic [memory_size_log-1:0]   w_Sel_Addr;
   logic [data_width-1:0]        w_Sel_Data;
   logic                         w_Sel_Write;
   logic [PW-1:0]                w_Next_Pointer;

   // Round-robin scan r_Pointer, r_Pointer+1, ... (mod p); the loop runs
   // backwards so the last hit written is the first one in scan order.
   always_comb begin : rr_select
      logic [PW:0] v_idx;
      v_idx   = '0;
      w_Found = 1'b0;
      w_Sel   = '0;
      for (int i = p - 1; i >= 0; i--) begin
         v_idx = {1'b0, r_Pointer} + (PW+1)'(i);
         if (v_idx >= (PW+1)'(p)) begin
            v_idx = v_idx - (PW+1)'(p);
         end
         if (i_Req[v_idx[PW-1:0]]) begin
            w_Found = 1'b1;
            w_Sel   = v_idx[PW-1:0];
         end
      end
   end

   assign w_Sel_Addr  = i_Addr[w_Sel*memory_size_log +: memory_size_log];
   assign w_Sel_Data  = i_Write_Data[w_Sel*data_width +: data_width];
   assign w_Sel_Write = i_Write[w_Sel];

   // Explicit wrap so a non-power-of-two p never lands on an unused index.
   assign w_Next_Pointer = (r_Winner == PW'(p - 1)) ? '0 : r_Winner + PW'(1);

   // Arbitration FSM; every output is a register updated here.
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         r_State            <= s_Idle;
         r_Pointer          <= '0;
         r_Winner           <= '0;
         r_Win_Cu           <= 1'b0;
         r_Win_Write        <= 1'b0;
         r_Grant            <= '0;
         r_Ack              <= '0;
         r_Mem_Addr         <= '0;
         r_Mem_Write_Data   <= '0;
         r_Mem_Write_Enable <= 1'b0;
         r_Read_Data        <= '0;
      end else begin
         // Ack and write enable are single-cycle pulses unless re-armed below.
         r_Ack              <= '0;
         r_Mem_Write_Enable <= 1'b0;
         case (r_State)
            s_Idle: begin
               if (i_CU_Req) begin
                  r_Win_Cu           <= 1'b1;
                  r_Win_Write        <= 1'b1;
                  r_Grant            <= {1'b1, {p{1'b0}}};
                  r_Mem_Addr         <= i_CU_Addr;
                  r_Mem_Write_Data   <= i_CU_Write_Data;
                  r_Mem_Write_Enable <= 1'b1;
                  r_State            <= s_Access;
               end else if (w_Found) begin
                  r_Win_Cu           <= 1'b0;
                  r_Winner           <= w_Sel;
                  r_Win_Write        <= w_Sel_Write;
                  r_Grant            <= (p+1)'(1) << w_Sel;
                  r_Mem_Addr         <= w_Sel_Addr;
                  r_Mem_Write_Data   <= w_Sel_Data;
                  r_Mem_Write_Enable <= w_Sel_Write;
                  r_State            <= s_Access;
               end
            end
            s_Access: begin
               // Memory sees the address this cycle; read data follows next cycle.
               r_State <= s_Respond;
            end
            s_Respond: begin
               r_Grant <= '0;
               if (r_Win_Cu) begin
                  r_Ack <= {1'b1, {p{1'b0}}};
               end else begin
                  r_Ack     <= (p+1)'(1) << r_Winner;
                  r_Pointer <= w_Next_Pointer;
               end
               // Captured together with the ack so the data is qualified by it.
               if (!r_Win_Write) begin
                  r_Read_Data <= i_Mem_Read_Data;
               end
               r_State <= s_Idle;
            end
            default: begin
               r_State <= s_Idle;
            end
         endcase
      end
   end

   assign o_Mem_Addr         = r_Mem_Addr;
   assign o_Mem_Write_Data   = r_Mem_Write_Data;
   assign o_Mem_Write_Enable = r_Mem_Write_Enable;
   assign o_Grant            = r_Grant;
   assign o_Ack              = r_Ack;
   assign o_Read_Data        = r_Read_Data;

endmodule
